// File: rtl/issue_lane_pipe_reg_if.sv
// Bundle bus between issue stages: LANES per-lane valid/kill bits, packed payload, and one ready.
// Handshake: a bundle transfers on a rising edge when |valid & ready; the master may not retract valid/payload while ready is low.
interface issue_lane_pipe_reg_if #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 128
);
    logic [LANES-1:0]           valid;
    logic [LANES*PAYLOAD_W-1:0] payload;
    logic [LANES-1:0]           kill;
    logic                       ready;

    modport master (output valid, output payload, output kill, input ready);
    modport slave  (input valid, input payload, input kill, output ready);
endinterface

// File: rtl/issue_lane_pipe_reg.sv
// N-lane ID->EX bundle register with per-lane kill, flush and bubble handling.
// Define ISSUE_PIPE_SKID_EN for a registered in_ready via a second (skid) bundle; state_o: 0=EMPTY 1=BUSY 2=SKID.
module issue_lane_pipe_reg #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 128
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        flush,
    issue_lane_pipe_reg_if.slave        in_i,
    issue_lane_pipe_reg_if.master       out_o,
    output logic [1:0]                  state_o
);
    localparam int BW = LANES * PAYLOAD_W;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;

    logic [LANES-1:0] cap_valid;
    logic [BW-1:0]    cap_payload;
    logic             in_fire;
    logic             out_fire;

    logic [LANES-1:0] main_valid_q, main_valid_d;
    logic [BW-1:0]    main_payload_q, main_payload_d;

    // Killed or invalid lanes are zeroed so EX never sees stale control bits.
    always_comb begin
        cap_valid   = in_i.valid & ~in_i.kill;
        cap_payload = '0;
        for (int k = 0; k < LANES; k++) begin
            if (cap_valid[k]) begin
                cap_payload[k*PAYLOAD_W +: PAYLOAD_W] = in_i.payload[k*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    assign in_fire  = in_i.ready & (|in_i.valid) & ~flush;
    assign out_fire = (|main_valid_q) & out_o.ready;

    assign out_o.valid   = main_valid_q;
    assign out_o.payload = main_payload_q;
    assign out_o.kill    = '0;

`ifdef ISSUE_PIPE_SKID_EN
    localparam logic [1:0] ST_SKID = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [LANES-1:0] skid_valid_q, skid_valid_d;
    logic [BW-1:0]    skid_payload_q, skid_payload_d;
    logic             in_load;

    // An all-killed bundle is accepted but never occupies a register.
    assign in_load = in_fire & (|cap_valid);

    always_comb begin
        state_d        = state_q;
        main_valid_d   = main_valid_q;
        main_payload_d = main_payload_q;
        skid_valid_d   = skid_valid_q;
        skid_payload_d = skid_payload_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_load) begin
                    main_valid_d   = cap_valid;
                    main_payload_d = cap_payload;
                    state_d        = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_load && !out_o.ready) begin
                    skid_valid_d   = cap_valid;
                    skid_payload_d = cap_payload;
                    state_d        = ST_SKID;
                end else if (in_load) begin
                    main_valid_d   = cap_valid;
                    main_payload_d = cap_payload;
                end else if (out_fire) begin
                    main_valid_d   = '0;
                    main_payload_d = '0;
                    state_d        = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_fire) begin
                    main_valid_d   = skid_valid_q;
                    main_payload_d = skid_payload_q;
                    skid_valid_d   = '0;
                    skid_payload_d = '0;
                    state_d        = ST_BUSY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            main_valid_d   = '0;
            main_payload_d = '0;
            skid_valid_d   = '0;
            skid_payload_d = '0;
            state_d        = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_EMPTY;
            skid_valid_q   <= '0;
            skid_payload_q <= '0;
        end else begin
            state_q        <= state_d;
            skid_valid_q   <= skid_valid_d;
            skid_payload_q <= skid_payload_d;
        end
    end

    assign in_i.ready = (state_q != ST_SKID);
    assign state_o    = state_q;
`else
    always_comb begin
        main_valid_d   = main_valid_q;
        main_payload_d = main_payload_q;
        if (flush) begin
            main_valid_d   = '0;
            main_payload_d = '0;
        end else if (in_fire) begin
            main_valid_d   = cap_valid;
            main_payload_d = cap_payload;
        end else if (out_fire) begin
            main_valid_d   = '0;
            main_payload_d = '0;
        end
    end

    // Combinational from out_ready: a held bundle frees the slot in the cycle EX takes it.
    assign in_i.ready = ~(|main_valid_q) | out_o.ready;
    assign state_o    = (|main_valid_q) ? ST_BUSY : ST_EMPTY;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            main_valid_q   <= '0;
            main_payload_q <= '0;
        end else begin
            main_valid_q   <= main_valid_d;
            main_payload_q <= main_payload_d;
        end
    end
endmodule

// File: tb/tb_issue_lane_pipe_reg.sv
// Bench: vector table and directed sequences on a 2x8 instance, reset and random scoreboard stress on a 4x32 instance.
module tb_issue_lane_pipe_reg;
    localparam logic [1:0] ST_EMPTY = 2'd0;
`ifdef ISSUE_PIPE_SKID_EN
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;
`endif
    localparam int BQW = 4 + 4*32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic a_flush = 1'b0;
    logic b_flush = 1'b0;
    logic [1:0] a_state, b_state;
    int n_checks = 0;
    int n_errors = 0;
    logic [BQW-1:0] exp_q[$];

    issue_lane_pipe_reg_if #(.LANES(2), .PAYLOAD_W(8))  a_in ();
    issue_lane_pipe_reg_if #(.LANES(2), .PAYLOAD_W(8))  a_out ();
    issue_lane_pipe_reg_if #(.LANES(4), .PAYLOAD_W(32)) b_in ();
    issue_lane_pipe_reg_if #(.LANES(4), .PAYLOAD_W(32)) b_out ();

    issue_lane_pipe_reg #(.LANES(2), .PAYLOAD_W(8)) u_a (
        .clk(clk), .resetn(resetn), .flush(a_flush),
        .in_i(a_in), .out_o(a_out), .state_o(a_state)
    );
    issue_lane_pipe_reg #(.LANES(4), .PAYLOAD_W(32)) u_b (
        .clk(clk), .resetn(resetn), .flush(b_flush),
        .in_i(b_in), .out_o(b_out), .state_o(b_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic contig(input logic [3:0] v);
        return ((v + 4'd1) & v) == 4'd0;
    endfunction

    always @(posedge clk) begin
        if (resetn) begin
            assert (contig({2'b00, a_in.valid}) && contig(b_in.valid))
                else $error("non-contiguous in_valid driven");
        end
    end

    // scoreboard helpers
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane capture rule: only valid & !kill lanes survive, others read as zero.
    function automatic logic [BQW-1:0] capture(input logic [3:0] iv, input logic [3:0] ik,
                                               input logic [127:0] ip);
        logic [3:0]   v;
        logic [127:0] p;
        v = 4'h0;
        p = '0;
        for (int k = 0; k < 4; k++) begin
            if (iv[k] && !ik[k]) begin
                v[k] = 1'b1;
                p[k*32 +: 32] = ip[k*32 +: 32];
            end
        end
        return {v, p};
    endfunction

    // drivers
    task automatic a_set(input logic fl, input logic [1:0] iv, input logic [1:0] ik,
                         input logic [15:0] ip, input logic ordy);
        @(negedge clk);
        a_flush = fl;
        a_in.valid = iv;
        a_in.kill = ik;
        a_in.payload = ip;
        a_out.ready = ordy;
        #1;
    endtask

    task automatic b_set(input logic fl, input logic [3:0] iv, input logic [3:0] ik,
                         input logic [127:0] ip, input logic ordy);
        @(negedge clk);
        b_flush = fl;
        b_in.valid = iv;
        b_in.kill = ik;
        b_in.payload = ip;
        b_out.ready = ordy;
        #1;
    endtask

    typedef struct packed {
        logic        fl;
        logic [1:0]  iv;
        logic [1:0]  ik;
        logic [15:0] ip;
        logic        ordy;
        logic        exp_ir;
        logic [1:0]  exp_ov;
        logic [15:0] exp_op;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [127:0] p1, p2, ip;
        logic [3:0]   iv, ik;
        logic         fl, ordy, exp_ir, in_fire;
        logic [BQW-1:0] cap;
        int n;

        // Expected outputs are those visible in the same cycle, before the edge that applies the row.
        tbl[0]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 2'b00, 16'h0000};
        tbl[1]  = '{1'b0, 2'b11, 2'b00, 16'hB2A1, 1'b1, 1'b1, 2'b00, 16'h0000};
        tbl[2]  = '{1'b0, 2'b11, 2'b00, 16'hD4C3, 1'b1, 1'b1, 2'b11, 16'hB2A1};
        tbl[3]  = '{1'b0, 2'b11, 2'b10, 16'hF6E5, 1'b1, 1'b1, 2'b11, 16'hD4C3};
        tbl[4]  = '{1'b0, 2'b11, 2'b11, 16'h1234, 1'b1, 1'b1, 2'b01, 16'h00E5};
        tbl[5]  = '{1'b0, 2'b01, 2'b00, 16'hABCD, 1'b1, 1'b1, 2'b00, 16'h0000};
        tbl[6]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 2'b01, 16'h00CD};
        tbl[7]  = '{1'b0, 2'b11, 2'b01, 16'h7788, 1'b1, 1'b1, 2'b00, 16'h0000};
        tbl[8]  = '{1'b1, 2'b11, 2'b00, 16'h5566, 1'b1, 1'b1, 2'b10, 16'h7700};
        tbl[9]  = '{1'b0, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 2'b00, 16'h0000};
        tbl[10] = '{1'b0, 2'b01, 2'b00, 16'h0099, 1'b1, 1'b1, 2'b00, 16'h0000};
        tbl[11] = '{1'b0, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 2'b01, 16'h0099};
        tbl[12] = '{1'b0, 2'b00, 2'b00, 16'h0000, 1'b1, 1'b1, 2'b00, 16'h0000};

        a_in.valid = '0; a_in.kill = '0; a_in.payload = '0; a_out.ready = 1'b1;
        b_in.valid = '0; b_in.kill = '0; b_in.payload = '0; b_out.ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // table-driven streaming, kill, bubble and flush
        for (int i = 0; i < 13; i++) begin
            a_set(tbl[i].fl, tbl[i].iv, tbl[i].ik, tbl[i].ip, tbl[i].ordy);
            chk($sformatf("tbl%0d_in_ready", i), 256'(a_in.ready), 256'(tbl[i].exp_ir));
            chk($sformatf("tbl%0d_out_valid", i), 256'(a_out.valid), 256'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_out_payload", i), 256'(a_out.payload), 256'(tbl[i].exp_op));
        end

        // hold with out_ready low for three cycles
        a_set(1'b0, 2'b11, 2'b00, 16'h1122, 1'b0);
        chk("hold_load_ready", 256'(a_in.ready), 256'(1));
`ifdef ISSUE_PIPE_SKID_EN
        a_set(1'b0, 2'b11, 2'b00, 16'h3344, 1'b0);
        chk("hold_skid_accept", 256'(a_in.ready), 256'(1));
        chk("hold_busy_state", 256'(a_state), 256'(ST_BUSY));
        chk("hold_c1_payload", 256'({a_out.valid, a_out.payload}), 256'({2'b11, 16'h1122}));
        for (int c = 2; c <= 3; c++) begin
            a_set(1'b0, 2'b11, 2'b00, 16'h5566, 1'b0);
            chk($sformatf("hold_c%0d_payload", c), 256'({a_out.valid, a_out.payload}), 256'({2'b11, 16'h1122}));
            chk($sformatf("hold_c%0d_ready", c), 256'(a_in.ready), 256'(0));
            chk($sformatf("hold_c%0d_state", c), 256'(a_state), 256'(ST_SKID));
        end
        a_set(1'b0, 2'b00, 2'b00, 16'h0000, 1'b1);
        chk("drain_first", 256'({a_out.valid, a_out.payload}), 256'({2'b11, 16'h1122}));
        a_set(1'b0, 2'b00, 2'b00, 16'h0000, 1'b1);
        chk("drain_second", 256'({a_out.valid, a_out.payload}), 256'({2'b11, 16'h3344}));
        chk("drain_ready", 256'(a_in.ready), 256'(1));
`else
        for (int c = 1; c <= 3; c++) begin
            a_set(1'b0, 2'b11, 2'b00, 16'h3344, 1'b0);
            chk($sformatf("hold_c%0d_payload", c), 256'({a_out.valid, a_out.payload}), 256'({2'b11, 16'h1122}));
            chk($sformatf("hold_c%0d_ready", c), 256'(a_in.ready), 256'(0));
        end
        a_set(1'b0, 2'b11, 2'b00, 16'h3344, 1'b1);
        chk("release_ready", 256'(a_in.ready), 256'(1));
        chk("release_old", 256'({a_out.valid, a_out.payload}), 256'({2'b11, 16'h1122}));
        a_set(1'b0, 2'b00, 2'b00, 16'h0000, 1'b1);
        chk("release_new", 256'({a_out.valid, a_out.payload}), 256'({2'b11, 16'h3344}));
`endif
        a_set(1'b0, 2'b00, 2'b00, 16'h0000, 1'b1);
        chk("hold_end_empty", 256'({a_out.valid, a_out.payload}), 256'(0));

        // flush with a bundle held and a new bundle offered
        a_set(1'b0, 2'b11, 2'b00, 16'h9A8B, 1'b0);
        a_set(1'b1, 2'b11, 2'b00, 16'hCDEF, 1'b0);
        chk("flush_pre_held", 256'({a_out.valid, a_out.payload}), 256'({2'b11, 16'h9A8B}));
        a_set(1'b0, 2'b00, 2'b00, 16'h0000, 1'b1);
        chk("flush_out", 256'({a_out.valid, a_out.payload}), 256'(0));
        chk("flush_state", 256'(a_state), 256'(ST_EMPTY));
        chk("flush_ready", 256'(a_in.ready), 256'(1));
        a_set(1'b0, 2'b00, 2'b00, 16'h0000, 1'b1);
        chk("flush_no_ghost", 256'({a_out.valid, a_out.payload}), 256'(0));

        // reset while two bundles are outstanding on the wide instance
        p1 = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom, $urandom, $urandom};
        b_set(1'b0, 4'hF, 4'h0, p1, 1'b0);
        b_set(1'b0, 4'hF, 4'h0, p2, 1'b0);
        chk("rst_pre_held", 256'({b_out.valid, b_out.payload}), 256'({4'hF, p1}));
        @(negedge clk);
        resetn = 1'b0;
        b_in.valid = '0;
        #1;
`ifdef ISSUE_PIPE_SKID_EN
        chk("rst_pre_state", 256'(b_state), 256'(ST_SKID));
`endif
        @(negedge clk);
        #1;
        chk("rst_out", 256'({b_out.valid, b_out.payload}), 256'(0));
        chk("rst_state", 256'(b_state), 256'(ST_EMPTY));
        resetn = 1'b1;
        b_set(1'b0, 4'h0, 4'h0, '0, 1'b1);
        chk("rst_release_ready", 256'(b_in.ready), 256'(1));
        chk("rst_release_out", 256'({b_out.valid, b_out.payload}), 256'(0));

        // random stress against a bundle-queue model
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n    = $urandom_range(0, 4);
            iv   = 4'((1 << n) - 1);
            ik   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            ip   = {$urandom, $urandom, $urandom, $urandom};
            ordy = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 31) == 0);
            b_set(fl, iv, ik, ip, ordy);
`ifdef ISSUE_PIPE_SKID_EN
            exp_ir = (exp_q.size() < 2);
`else
            exp_ir = (exp_q.size() == 0) || ordy;
`endif
            chk("rnd_in_ready", 256'(b_in.ready), 256'(exp_ir));
            if (exp_q.size() == 0)
                chk("rnd_out_empty", 256'({b_out.valid, b_out.payload}), 256'(0));
            else
                chk("rnd_out_bundle", 256'({b_out.valid, b_out.payload}), 256'(exp_q[0]));
            in_fire = exp_ir && (iv != 4'h0) && !fl;
            cap = capture(iv, ik, ip);
            if (fl) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
                if (in_fire && cap[BQW-1 -: 4] != 4'h0) exp_q.push_back(cap);
            end
        end

        b_set(1'b0, 4'h0, 4'h0, '0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
